// File: rtl/uart_sort_ctrl.sv
// uart_sort_ctrl: sequences rx -> sorter -> tx hand-off with credit-based
// flow control, a one-deep pending slot, end-of-batch drain and error latch.
// Optional statistics counters are built only when UART_SORT_CTRL_STATS_EN
// is defined; otherwise seq_cnt and stall_cnt are tied to zero.
module uart_sort_ctrl #(
  parameter int unsigned NUM_SEQ = 10,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned CR_W   = $clog2(NUM_SEQ + 1),
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_valid,
  input  logic             data_end,
  input  logic             sort_done,
  input  logic             tx_full,
  input  logic             tx_busy,
  input  logic             tx_seq_sent,
  input  logic             err_clr,
  output logic             sort_start,
  output logic             batch_done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CR_W-1:0]  credits,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] seq_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_SORTING = 3'd2,
    S_DRAIN   = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [CR_W-1:0] CREDITS_FULL = CR_W'(NUM_SEQ);
  localparam logic [TO_W-1:0] TIMER_LIMIT  = TO_W'(TIMEOUT);

  state_t          st;
  logic            pending;
  logic            end_flag;
  logic [TO_W-1:0] timer;

  logic       room;
  logic       accept;
  logic       overflow;
  logic       spurious;
  logic       timeout;
  logic       err_hit;
  logic [1:0] err_next;
  logic       drain_done;

  assign error = (st == S_ERROR);
  assign state = st;

  // Decode acceptance, drain completion and error conditions for this cycle
  always_comb begin
    room       = (credits != '0) && !tx_full;
    overflow   = (st != S_ERROR) && seq_valid && pending;
    spurious   = (st != S_ERROR) && (st != S_SORTING) && sort_done;
    timeout    = (st == S_SORTING) && !sort_done && (timer == TIMER_LIMIT);
    err_hit    = overflow || spurious || timeout;
    err_next   = 2'b00;
    if (timeout)
      err_next = 2'b01;
    else if (overflow)
      err_next = 2'b10;
    else if (spurious)
      err_next = 2'b11;
    // an error in the same cycle suppresses acceptance, so no sort_start escapes
    accept     = (st == S_IDLE) && (seq_valid || pending) && room && !err_hit;
    drain_done = (st == S_DRAIN) && (credits == CREDITS_FULL) && !tx_busy;
  end

  // Main control FSM with registered sort_start / batch_done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      sort_start <= 1'b0;
      batch_done <= 1'b0;
      err_code   <= 2'b00;
      credits    <= CREDITS_FULL;
      pending    <= 1'b0;
      end_flag   <= 1'b0;
      timer      <= '0;
    end else begin
      sort_start <= 1'b0;
      batch_done <= 1'b0;
      if (st == S_ERROR) begin
        if (err_clr) begin
          st       <= S_IDLE;
          err_code <= 2'b00;
          credits  <= CREDITS_FULL;
          pending  <= 1'b0;
          end_flag <= 1'b0;
          timer    <= '0;
        end
      end else if (err_hit) begin
        st       <= S_ERROR;
        err_code <= err_next;
      end else begin
        // simultaneous issue and tx return cancel out; returns saturate at full
        if (accept && !tx_seq_sent)
          credits <= credits - 1'b1;
        else if (!accept && tx_seq_sent && (credits < CREDITS_FULL))
          credits <= credits + 1'b1;

        pending <= (pending || seq_valid) && !accept;

        if (data_end)
          end_flag <= 1'b1;
        else if (drain_done)
          end_flag <= 1'b0;

        if (accept)
          timer <= '0;
        else if (((st == S_ISSUE) || (st == S_SORTING)) && (timer < TIMER_LIMIT))
          timer <= timer + 1'b1;

        case (st)
          S_IDLE: begin
            if (accept) begin
              st         <= S_ISSUE;
              sort_start <= 1'b1;
            end else if (end_flag && !pending) begin
              st <= S_DRAIN;
            end
          end
          S_ISSUE: st <= S_SORTING;
          S_SORTING: begin
            if (sort_done)
              st <= S_IDLE;
          end
          S_DRAIN: begin
            if (drain_done) begin
              st         <= S_IDLE;
              batch_done <= 1'b1;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_SORT_CTRL_STATS_EN
  // Saturating statistics: sorted sequences and cycles stalled on tx space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if ((st == S_SORTING) && sort_done && (seq_cnt != '1))
        seq_cnt <= seq_cnt + 1'b1;
      if (pending && ((credits == '0) || tx_full) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign seq_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_sort_ctrl.sv
// Directed self-checking bench for uart_sort_ctrl (default parameters).
module tb_uart_sort_ctrl;

`ifdef UART_SORT_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int unsigned TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seq_valid = 1'b0;
  logic        data_end = 1'b0;
  logic        sort_done = 1'b0;
  logic        tx_full = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_seq_sent = 1'b0;
  logic        err_clr = 1'b0;
  logic        sort_start;
  logic        batch_done;
  logic        error;
  logic [1:0]  err_code;
  logic [3:0]  credits;
  logic [2:0]  state;
  logic [15:0] seq_cnt;
  logic [15:0] stall_cnt;

  int vec  = 0;
  int miss = 0;

  uart_sort_ctrl #(.NUM_SEQ(10), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .seq_valid(seq_valid), .data_end(data_end),
    .sort_done(sort_done), .tx_full(tx_full), .tx_busy(tx_busy),
    .tx_seq_sent(tx_seq_sent), .err_clr(err_clr), .sort_start(sort_start),
    .batch_done(batch_done), .error(error), .err_code(err_code),
    .credits(credits), .state(state), .seq_cnt(seq_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // one full sequence: accept, issue, sorter answers right away
  task automatic run_seq();
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    tick();
    sort_done = 1'b1; tick(); sort_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vec++; if (state !== 3'd0) begin miss++; $display("FAIL reset_state: got %0d expected 0", state); end
    vec++; if (sort_start !== 1'b0 || batch_done !== 1'b0) begin miss++; $display("FAIL reset_pulses: got %0b%0b expected 00", sort_start, batch_done); end
    vec++; if (error !== 1'b0 || err_code !== 2'b00) begin miss++; $display("FAIL reset_err: got %0b/%0d expected 0/0", error, err_code); end
    vec++; if (credits !== 4'd10) begin miss++; $display("FAIL reset_credits: got %0d expected 10", credits); end
    vec++; if (seq_cnt !== 16'd0 || stall_cnt !== 16'd0) begin miss++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", seq_cnt, stall_cnt); end
  endtask

  task automatic test_single();
    apply_reset();
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    vec++; if (sort_start !== 1'b1) begin miss++; $display("FAIL single_start: got %0b expected 1", sort_start); end
    vec++; if (credits !== 4'd9) begin miss++; $display("FAIL single_credits: got %0d expected 9", credits); end
    tick();
    vec++; if (sort_start !== 1'b0 || state !== 3'd2) begin miss++; $display("FAIL single_sorting: got start=%0b state=%0d expected 0/2", sort_start, state); end
    repeat (18) tick();
    sort_done = 1'b1; tick(); sort_done = 1'b0;
    vec++; if (state !== 3'd0 || error !== 1'b0) begin miss++; $display("FAIL single_idle: got state=%0d err=%0b expected 0/0", state, error); end
    vec++; if (seq_cnt !== (STATS ? 16'd1 : 16'd0)) begin miss++; $display("FAIL single_seq_cnt: got %0d expected %0d", seq_cnt, STATS ? 1 : 0); end
    tx_seq_sent = 1'b1; tick(); tx_seq_sent = 1'b0;
    vec++; if (credits !== 4'd10) begin miss++; $display("FAIL single_return: got %0d expected 10", credits); end
  endtask

  task automatic test_credits();
    apply_reset();
    run_seq();
    seq_valid = 1'b1; tx_seq_sent = 1'b1; tick(); seq_valid = 1'b0; tx_seq_sent = 1'b0;
    vec++; if (credits !== 4'd9 || sort_start !== 1'b1) begin miss++; $display("FAIL credits_same_cycle: got %0d start=%0b expected 9/1", credits, sort_start); end
    tick();
    sort_done = 1'b1; tick(); sort_done = 1'b0;
    tx_seq_sent = 1'b1; tick(); tick(); tx_seq_sent = 1'b0;
    vec++; if (credits !== 4'd10) begin miss++; $display("FAIL credits_saturate: got %0d expected 10", credits); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 10; i++) run_seq();
    vec++; if (credits !== 4'd0 || state !== 3'd0) begin miss++; $display("FAIL bp_empty: got credits=%0d state=%0d expected 0/0", credits, state); end
    vec++; if (seq_cnt !== (STATS ? 16'd10 : 16'd0)) begin miss++; $display("FAIL bp_seq_cnt: got %0d expected %0d", seq_cnt, STATS ? 10 : 0); end
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    vec++; if (sort_start !== 1'b0 || error !== 1'b0) begin miss++; $display("FAIL bp_blocked: got start=%0b err=%0b expected 0/0", sort_start, error); end
    repeat (3) tick();
    vec++; if (stall_cnt !== (STATS ? 16'd3 : 16'd0)) begin miss++; $display("FAIL bp_stall3: got %0d expected %0d", stall_cnt, STATS ? 3 : 0); end
    tx_seq_sent = 1'b1; tick(); tx_seq_sent = 1'b0;
    vec++; if (sort_start !== 1'b0 || credits !== 4'd1) begin miss++; $display("FAIL bp_return: got start=%0b credits=%0d expected 0/1", sort_start, credits); end
    tick();
    vec++; if (sort_start !== 1'b1 || credits !== 4'd0) begin miss++; $display("FAIL bp_pending_issue: got start=%0b credits=%0d expected 1/0", sort_start, credits); end
    vec++; if (stall_cnt !== (STATS ? 16'd4 : 16'd0)) begin miss++; $display("FAIL bp_stall4: got %0d expected %0d", stall_cnt, STATS ? 4 : 0); end
    tick();
    sort_done = 1'b1; tick(); sort_done = 1'b0;
    vec++; if (state !== 3'd0 || error !== 1'b0) begin miss++; $display("FAIL bp_done: got state=%0d err=%0b expected 0/0", state, error); end
  endtask

  task automatic test_overflow();
    int starts;
    apply_reset();
    tx_full = 1'b1;
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    vec++; if (sort_start !== 1'b0 || error !== 1'b0) begin miss++; $display("FAIL ovf_pending: got start=%0b err=%0b expected 0/0", sort_start, error); end
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    vec++; if (error !== 1'b1 || err_code !== 2'b10 || state !== 3'd4) begin miss++; $display("FAIL ovf_error: got err=%0b code=%0d state=%0d expected 1/2/4", error, err_code, state); end
    tx_full = 1'b0;
    starts = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (sort_start) starts++; end
    vec++; if (starts !== 0 || state !== 3'd4) begin miss++; $display("FAIL ovf_hold: got starts=%0d state=%0d expected 0/4", starts, state); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vec++; if (state !== 3'd0 || credits !== 4'd10 || err_code !== 2'b00 || error !== 1'b0) begin miss++; $display("FAIL ovf_clear: got state=%0d credits=%0d code=%0d expected 0/10/0", state, credits, err_code); end
    tick();
    vec++; if (sort_start !== 1'b0) begin miss++; $display("FAIL ovf_pending_cleared: got %0b expected 0", sort_start); end
  endtask

  task automatic test_timeout();
    apply_reset();
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    repeat (TIMEOUT) tick();
    vec++; if (error !== 1'b0 || state !== 3'd2) begin miss++; $display("FAIL to_edge: got err=%0b state=%0d expected 0/2", error, state); end
    tick();
    vec++; if (error !== 1'b1 || err_code !== 2'b01) begin miss++; $display("FAIL to_error: got err=%0b code=%0d expected 1/1", error, err_code); end
    sort_done = 1'b1; tick(); sort_done = 1'b0;
    vec++; if (err_code !== 2'b01 || state !== 3'd4) begin miss++; $display("FAIL to_late_done: got code=%0d state=%0d expected 1/4", err_code, state); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vec++; if (state !== 3'd0) begin miss++; $display("FAIL to_clear: got %0d expected 0", state); end
  endtask

  task automatic test_drain();
    int pulses;
    apply_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) run_seq();
    data_end = 1'b1; tick(); data_end = 1'b0;
    tick();
    vec++; if (state !== 3'd3 || credits !== 4'd7) begin miss++; $display("FAIL drain_enter: got state=%0d credits=%0d expected 3/7", state, credits); end
    tx_seq_sent = 1'b1; repeat (3) tick(); tx_seq_sent = 1'b0;
    tick(); tick();
    vec++; if (batch_done !== 1'b0 || state !== 3'd3 || credits !== 4'd10) begin miss++; $display("FAIL drain_busy: got bd=%0b state=%0d credits=%0d expected 0/3/10", batch_done, state, credits); end
    tx_busy = 1'b0; tick();
    vec++; if (batch_done !== 1'b1 || state !== 3'd0) begin miss++; $display("FAIL drain_done: got bd=%0b state=%0d expected 1/0", batch_done, state); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (batch_done) pulses++; end
    vec++; if (pulses !== 0 || state !== 3'd0) begin miss++; $display("FAIL drain_single: got extra=%0d state=%0d expected 0/0", pulses, state); end
  endtask

  task automatic test_reset_mid_sort();
    apply_reset();
    seq_valid = 1'b1; tick(); seq_valid = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    vec++; if (state !== 3'd0 || credits !== 4'd10 || sort_start !== 1'b0) begin miss++; $display("FAIL rst_async: got state=%0d credits=%0d expected 0/10", state, credits); end
    tick(); rst = 1'b0; tick();
    sort_done = 1'b1; tick(); sort_done = 1'b0;
    vec++; if (error !== 1'b1 || err_code !== 2'b11) begin miss++; $display("FAIL rst_spurious: got err=%0b code=%0d expected 1/3", error, err_code); end
    vec++; if (seq_cnt !== 16'd0) begin miss++; $display("FAIL rst_seq_cnt: got %0d expected 0", seq_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credits();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_drain();
    test_reset_mid_sort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_sort_ctrl.md
UART_SORT_CTRL -- requirements
Module: uart_sort_ctrl

Interface
REQ-001 Parameter NUM_SEQ, default 10: number of sorted sequences the tx buffer can hold, which is also the initial credit count.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles from sort_start to sort_done before an error is declared.
REQ-003 Parameter CNT_W, default 16: width of the statistics counters.
REQ-004 Port `clk`, input, 1: single clock. Port `rst`, input, 1: reset, asynchronous and active-high.
REQ-005 Port `seq_valid`, input, 1: one-cycle pulse from the rx buffer meaning a full unsorted sequence is ready.
REQ-006 Port `data_end`, input, 1: one-cycle pulse meaning the end of the batch has been received.
REQ-007 Port `sort_done`, input, 1: valid_out pulse from the sorter.
REQ-008 Port `tx_full`, input, 1: the tx buffer is full.
REQ-009 Port `tx_busy`, input, 1: the UART transmitter is busy.
REQ-010 Port `tx_seq_sent`, input, 1: one-cycle pulse when the tx buffer has finished emitting a whole sequence.
REQ-011 Port `err_clr`, input, 1: clears the ERROR state.
REQ-012 Port `sort_start`, output, 1: registered valid_in pulse to the sorter.
REQ-013 Port `batch_done`, output, 1: one-cycle pulse when the batch has fully drained.
REQ-014 Port `error`, output, 1: level, high while the state is ERROR.
REQ-015 Port `err_code`, output, 2: 01 = timeout, 10 = overflow, 11 = spurious sort_done.
REQ-016 Port `credits`, output, $clog2(NUM_SEQ+1): free tx slots.
REQ-017 Port `state`, output, 3: current state encoding, for debug.
REQ-018 Port `seq_cnt`, output, CNT_W: sequences sorted.
REQ-019 Port `stall_cnt`, output, CNT_W: count of stall cycles.

Function
REQ-020 The block SHALL implement states IDLE=0, ISSUE=1, SORTING=2, DRAIN=3 and ERROR=4.
REQ-021 When a sequence is accepted, the block SHALL pass IDLE→ISSUE→SORTING→IDLE.
- An accepted sequence is seq_valid, or the pending flag, with credits>0 and !tx_full.
- ISSUE drives sort_start high for exactly one cycle, so sort_start is asserted 1 cycle after acceptance.
- ISSUE decrements credits.
REQ-022 In SORTING, sort_done SHALL return the block to IDLE.
- If TIMEOUT cycles elapse in SORTING without sort_done, the block SHALL go to ERROR with err_code=01.
REQ-023 A seq_valid that cannot be accepted immediately SHALL set a one-deep pending flag.
- A blocked seq_valid occurs when the state is not IDLE, or credits=0, or tx_full=1.
- The pending flag clears on the cycle its sequence is accepted.
- A seq_valid while the flag is already set SHALL cause ERROR with err_code=10.
REQ-024 A tx_seq_sent pulse SHALL increment credits.
- Credits saturate at NUM_SEQ.
- If tx_seq_sent and ISSUE occur in the same cycle, credits SHALL stay unchanged.
REQ-025 data_end SHALL set a sticky end flag.
- The block enters DRAIN from IDLE once the end flag is set and the pending flag is clear.
- In DRAIN, when credits=NUM_SEQ and !tx_busy, the block SHALL pulse batch_done for one cycle, clear the end flag, and return to IDLE.
REQ-026 A sort_done in any state other than SORTING SHALL cause ERROR with err_code=11.
REQ-027 In ERROR, sort_start SHALL be held at 0 and all inputs except err_clr SHALL be ignored.
- err_clr SHALL return the block to IDLE, with credits=NUM_SEQ, pending and end flags cleared, and err_code=00.
REQ-028 If err_clr and an error condition occur in the same cycle, the error condition SHALL take priority.
REQ-029 The timeout counter SHALL reset on entry to ISSUE.
- The counter is $clog2(TIMEOUT+1) bits wide and SHALL NOT wrap.

Reset
REQ-030 Asserting rst SHALL, asynchronously, set the state to IDLE, sort_start=0, batch_done=0, err_code=00, credits=NUM_SEQ, pending and end flags=0, and seq_cnt=stall_cnt=0.
REQ-031 Reset asserted mid-SORTING SHALL abandon the sequence in flight; a sort_done arriving after reset releases SHALL be treated as spurious (err_code=11).

Configuration
REQ-032 With UART_SORT_CTRL_STATS_EN defined, the statistics counters SHALL be active.
- seq_cnt increments on each sort_done accepted in SORTING.
- stall_cnt increments on each cycle the pending flag is set while credits=0 or tx_full=1.
- Both counters saturate at all-ones.
REQ-033 With UART_SORT_CTRL_STATS_EN undefined, the statistics logic SHALL be absent and seq_cnt and stall_cnt SHALL be tied to 0.
- All other behaviour is identical.

Verification
REQ-034 Single sequence: seq_valid at cycle 0 → sort_start at cycle 1 and credits=9; sort_done at cycle 20 → state=IDLE; tx_seq_sent → credits=10.
REQ-035 Backpressure: 10 sequences with no tx_seq_sent → credits=0; an 11th seq_valid sets pending and stall_cnt counts (STATS_EN); tx_seq_sent → sort_start 2 cycles later.
REQ-036 Overflow: pending set and a further seq_valid arrives → error=1, err_code=10, no sort_start; err_clr → IDLE and credits=10.
REQ-037 Timeout: sort_start with no sort_done for 1024 cycles → error=1, err_code=01; a later sort_done is ignored.
REQ-038 Drain: data_end after 3 sequences, tx_busy held high → no batch_done; 3 tx_seq_sent then tx_busy low → a single batch_done pulse and state=IDLE.
REQ-039 Reset mid-SORTING, then sort_done → credits=10 after reset, and err_code=11.
